jump_link_unit: RTL and testbench
=================================

Name: jump_link_unit

Overview:
- Parametrised successor to the JAL address-treatment logic; lives in the ID stage.
- Resolves J, JAL and JR, computes jump target and link address, and drives a one-cycle redirect to fetch.
- Adds a return-address stack (RAS) for JAL pushes and JR $ra pops, reporting whether the stack prediction matched the architectural register value.
- Outputs are registered, with one cycle of latency.

Parameters:
PC_WIDTH, 32, program-counter width in bits; must be >= JUMP_WIDTH+2
JUMP_WIDTH, 26, width of the J-type immediate field
RAS_DEPTH, 8, number of RAS entries; power of two, >= 2
LINK_OFFSET, 4, byte offset added to PC to form the return address

Ports:
ju_i_clk  in  1  clock, rising edge
ju_i_rst_n  in  1  reset, synchronous, active-low
ju_i_valid  in  1  a decoded instruction is present this cycle
ju_i_stall  in  1  ID stage stalled; input ignored
ju_i_flush  in  1  squash current ID instruction (EX redirect)
ju_i_jal  in  1  instruction is JAL
ju_i_j  in  1  instruction is J
ju_i_jr  in  1  instruction is JR
ju_i_rs_is_ra  in  1  JR source register is $31
ju_i_pc  in  PC_WIDTH  PC of the instruction in ID
ju_i_jump_addr  in  JUMP_WIDTH  J-type immediate
ju_i_rs_data  in  PC_WIDTH  forwarded rs value for JR
ju_o_redirect  out  1  one-cycle pulse: fetch must load ju_o_target
ju_o_target  out  PC_WIDTH  resolved next PC
ju_o_ra  out  PC_WIDTH  link value to write to $31
ju_o_link_we  out  1  write ju_o_ra into $31 (JAL only)
ju_o_ras_hit  out  1  JR $ra: RAS top equalled ju_i_rs_data
ju_o_ras_empty  out  1  JR $ra popped an empty RAS

Behaviour:
- Accept condition: accept = ju_i_valid & ~ju_i_stall & ~ju_i_flush. Flush has priority over stall.
- Opcode priority when more than one of jal/j/jr is set: jal > j > jr.
- Arithmetic:
  - pc4 = ju_i_pc + LINK_OFFSET, truncated to PC_WIDTH (wraps at the top of the address space).
  - J/JAL target = {pc4[PC_WIDTH-1:JUMP_WIDTH+2], ju_i_jump_addr, 2'b00}.
  - JR target = ju_i_rs_data.
- Outputs are registered on the edge after accept.
  - ju_o_redirect = 1 for exactly one cycle.
  - ju_o_target and ju_o_ra hold their values until the next accept.
  - ju_o_link_we, ju_o_ras_hit and ju_o_ras_empty are single-cycle pulses.
- If a cycle has no accept, or the accepted instruction is not a jump, the pulse outputs are 0 on the next cycle. Stalled or flushed cycles change no state.
- RAS: circular array with top pointer tp (log2 RAS_DEPTH bits) and occupancy count cnt (0..RAS_DEPTH).
  - JAL push: write pc4 at tp+1, tp increments modulo RAS_DEPTH, cnt saturates at RAS_DEPTH. On overflow the oldest entry is silently overwritten.
  - JR with ju_i_rs_is_ra, cnt > 0: pop. ras_hit = (entry[tp] == ju_i_rs_data); tp decrements; cnt decrements.
  - JR with ju_i_rs_is_ra, cnt == 0: ras_empty = 1, ras_hit = 0, no pointer change.
  - JR with another register: no RAS access; hit and empty are 0.
  - J: no RAS access.
- Redirect always uses the architectural target; RAS status is informational for the hazard unit.
- Reset (ju_i_rst_n low at a rising edge, including mid-sequence):
  - tp = 0, cnt = 0.
  - All outputs = 0.
  - RAS contents are don't-care.
  - The first cycle after reset release may accept.

Optional Feature:
- Macro: JUMP_LINK_RAS_STATS_EN.
- When defined: adds outputs ju_o_hit_cnt and ju_o_miss_cnt, both 16 bits. They are saturating counters of RAS pops with hit=1 and hit=0 (empty pops count as misses), and are cleared by reset.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header (existing defines file): PC_WIDTH, JUMP_WIDTH, REG_RA = 5'd31, LINK_OFFSET default.
- One sub-module, ras_stack, holds the array, tp and cnt, with push, pop, top, empty and full ports. It is parametrised by RAS_DEPTH and PC_WIDTH.
- Target/link arithmetic stays in the top module.

Test Plan:
- JAL, pc=0x00400000, addr=10 -> next cycle: redirect=1, target=0x00000028, ra=0x00400004, link_we=1; cycle after: redirect=0.
- JAL as above, then JR rs_is_ra with rs_data=0x00400004 -> ras_hit=1, target=0x00400004, link_we=0, cnt=0.
- 9 JALs with pc=0x100,0x200,...,0x900 (depth 8), then 9 JR $ra with matching rs_data in LIFO order -> first 8 pops hit=1 (0x904 down to 0x204), 9th ras_empty=1.
- JAL with ju_i_flush=1, then JR $ra rs_data=0x4 -> redirect 0 after flush; JR gives ras_empty=1. Repeat with ju_i_stall=1 -> same result.
- 3 JALs, ju_i_rst_n low for one edge, then JR $ra -> all outputs 0 during reset; JR gives ras_empty=1.
- JALs pushing 0x104 then 0x204, then JR $ra rs_data=0x999 -> ras_hit=0, target=0x999. With JUMP_LINK_RAS_STATS_EN: miss_cnt=1, hit_cnt=0.

Source files
------------

// File: rtl/jump_link_unit_pkg.sv
// Shared definitions for the jump/link unit: default widths and jump-kind decode.
package jump_link_unit_pkg;

  localparam int unsigned DefPcWidth    = 32;
  localparam int unsigned DefJumpWidth  = 26;
  localparam int unsigned DefRasDepth   = 8;
  localparam int unsigned DefLinkOffset = 4;
  localparam int unsigned StatWidth     = 16;

  typedef enum logic [1:0] {
    OpNone,
    OpJal,
    OpJ,
    OpJr
  } jump_op_e;

  // When several opcode bits are set, JAL wins over J, and J over JR.
  function automatic jump_op_e decode_op(logic jal, logic j, logic jr);
    if (jal) begin
      return OpJal;
    end else if (j) begin
      return OpJ;
    end else if (jr) begin
      return OpJr;
    end
    return OpNone;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular array with a top pointer and saturating occupancy count.
module ras_stack #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [PC_WIDTH-1:0] push_data,
  input  logic                pop,
  output logic [PC_WIDTH-1:0] top,
  output logic                empty
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]     tp_q, tp_d, tp_inc;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                full;

  always_comb begin
    tp_inc = tp_q + PtrW'(1);
    full   = (cnt_q == CntW'(RAS_DEPTH));
    empty  = (cnt_q == '0);
    top    = mem_q[tp_q];
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    if (push) begin
      // A push on a full stack overwrites the oldest entry; count stays saturated.
      tp_d = tp_inc;
      if (!full) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop && !empty) begin
      tp_d  = tp_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tp_inc] <= push_data;
    end
  end

endmodule

// File: rtl/jump_link_unit.sv
// ID-stage J/JAL/JR resolution with registered redirect, link value and RAS prediction status.
// Optional JUMP_LINK_RAS_STATS_EN adds saturating RAS hit/miss counters.
module jump_link_unit
  import jump_link_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = DefPcWidth,
  parameter int unsigned JUMP_WIDTH  = DefJumpWidth,
  parameter int unsigned RAS_DEPTH   = DefRasDepth,
  parameter int unsigned LINK_OFFSET = DefLinkOffset
) (
  input  logic                  ju_i_clk,
  input  logic                  ju_i_rst_n,
  input  logic                  ju_i_valid,
  input  logic                  ju_i_stall,
  input  logic                  ju_i_flush,
  input  logic                  ju_i_jal,
  input  logic                  ju_i_j,
  input  logic                  ju_i_jr,
  input  logic                  ju_i_rs_is_ra,
  input  logic [PC_WIDTH-1:0]   ju_i_pc,
  input  logic [JUMP_WIDTH-1:0] ju_i_jump_addr,
  input  logic [PC_WIDTH-1:0]   ju_i_rs_data,
  output logic                  ju_o_redirect,
  output logic [PC_WIDTH-1:0]   ju_o_target,
  output logic [PC_WIDTH-1:0]   ju_o_ra,
  output logic                  ju_o_link_we,
  output logic                  ju_o_ras_hit,
  output logic                  ju_o_ras_empty
`ifdef JUMP_LINK_RAS_STATS_EN
  ,
  output logic [StatWidth-1:0]  ju_o_hit_cnt,
  output logic [StatWidth-1:0]  ju_o_miss_cnt
`endif
);

  logic                accept;
  jump_op_e            op;
  logic [PC_WIDTH-1:0] pc4, jtarget, target_d;
  logic                ras_push, ras_pop_try, ras_pop, ras_empty, hit_d, empty_d;
  logic [PC_WIDTH-1:0] ras_top;

  logic                redirect_q, link_we_q, ras_hit_q, ras_empty_q;
  logic [PC_WIDTH-1:0] target_q, ra_q;

  always_comb begin
    accept = ju_i_valid & ~ju_i_stall & ~ju_i_flush;
    op     = accept ? decode_op(ju_i_jal, ju_i_j, ju_i_jr) : OpNone;
    pc4    = ju_i_pc + PC_WIDTH'(LINK_OFFSET);
    // Region bits come from pc4; the immediate replaces the word-aligned low part.
    jtarget                 = pc4;
    jtarget[JUMP_WIDTH+1:0] = {ju_i_jump_addr, 2'b00};

    target_d = jtarget;
    unique case (op)
      OpJr:    target_d = ju_i_rs_data;
      default: target_d = jtarget;
    endcase

    ras_push    = (op == OpJal);
    ras_pop_try = (op == OpJr) & ju_i_rs_is_ra;
    ras_pop     = ras_pop_try & ~ras_empty;
    hit_d       = ras_pop & (ras_top == ju_i_rs_data);
    empty_d     = ras_pop_try & ras_empty;
  end

  ras_stack #(
    .RAS_DEPTH(RAS_DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_ras (
    .clk      (ju_i_clk),
    .rst_n    (ju_i_rst_n),
    .push     (ras_push),
    .push_data(pc4),
    .pop      (ras_pop),
    .top      (ras_top),
    .empty    (ras_empty)
  );

  always_ff @(posedge ju_i_clk) begin
    if (!ju_i_rst_n) begin
      redirect_q  <= 1'b0;
      link_we_q   <= 1'b0;
      ras_hit_q   <= 1'b0;
      ras_empty_q <= 1'b0;
      target_q    <= '0;
      ra_q        <= '0;
    end else begin
      redirect_q  <= (op != OpNone);
      link_we_q   <= ras_push;
      ras_hit_q   <= hit_d;
      ras_empty_q <= empty_d;
      if (op != OpNone) begin
        target_q <= target_d;
        ra_q     <= pc4;
      end
    end
  end

  assign ju_o_redirect  = redirect_q;
  assign ju_o_target    = target_q;
  assign ju_o_ra        = ra_q;
  assign ju_o_link_we   = link_we_q;
  assign ju_o_ras_hit   = ras_hit_q;
  assign ju_o_ras_empty = ras_empty_q;

`ifdef JUMP_LINK_RAS_STATS_EN
  logic [StatWidth-1:0] hit_cnt_q, miss_cnt_q;

  // Empty pops count as misses.
  always_ff @(posedge ju_i_clk) begin
    if (!ju_i_rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (ras_pop_try) begin
      if (hit_d) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + StatWidth'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + StatWidth'(1);
      end
    end
  end

  assign ju_o_hit_cnt  = hit_cnt_q;
  assign ju_o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_jump_link_unit.sv
// Self-checking bench for jump_link_unit: directed vector table, LIFO/overflow sequence, random vs. model.
module tb_jump_link_unit;

  logic        clk = 1'b0;
  logic        rst_n, valid, stall, flush, jal, j, jr, rs_is_ra;
  logic [31:0] pc, rs_data;
  logic [25:0] jaddr;
  logic        redirect, link_we, ras_hit, ras_empty;
  logic [31:0] target, ra;
`ifdef JUMP_LINK_RAS_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jump_link_unit dut (
    .ju_i_clk      (clk),
    .ju_i_rst_n    (rst_n),
    .ju_i_valid    (valid),
    .ju_i_stall    (stall),
    .ju_i_flush    (flush),
    .ju_i_jal      (jal),
    .ju_i_j        (j),
    .ju_i_jr       (jr),
    .ju_i_rs_is_ra (rs_is_ra),
    .ju_i_pc       (pc),
    .ju_i_jump_addr(jaddr),
    .ju_i_rs_data  (rs_data),
    .ju_o_redirect (redirect),
    .ju_o_target   (target),
    .ju_o_ra       (ra),
    .ju_o_link_we  (link_we),
    .ju_o_ras_hit  (ras_hit),
    .ju_o_ras_empty(ras_empty)
`ifdef JUMP_LINK_RAS_STATS_EN
    ,
    .ju_o_hit_cnt  (hit_cnt),
    .ju_o_miss_cnt (miss_cnt)
`endif
  );

  typedef struct {
    logic        r, v, s, f, a, b, c, q;
    logic [31:0] pc;
    logic [25:0] ad;
    logic [31:0] rs;
    logic        er;
    logic [31:0] et, era;
    logic        el, eh, ee;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic s, logic f, logic a, logic b, logic c,
                              logic q, logic [31:0] p, logic [25:0] ad, logic [31:0] rs,
                              logic er, logic [31:0] et, logic [31:0] era, logic el,
                              logic eh, logic ee);
    vec_t x;
    x.r = r; x.v = v; x.s = s; x.f = f; x.a = a; x.b = b; x.c = c; x.q = q;
    x.pc = p; x.ad = ad; x.rs = rs;
    x.er = er; x.et = et; x.era = era; x.el = el; x.eh = eh; x.ee = ee;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic drive(logic r, logic v, logic s, logic f, logic a, logic b, logic c, logic q,
                       logic [31:0] p, logic [25:0] ad, logic [31:0] rs);
    rst_n = r; valid = v; stall = s; flush = f; jal = a; j = b; jr = c; rs_is_ra = q;
    pc = p; jaddr = ad; rs_data = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string tag, logic er, logic [31:0] et, logic [31:0] era, logic el,
                           logic eh, logic ee);
    check({tag, " redirect"}, 32'(redirect), 32'(er));
    check({tag, " target"}, target, et);
    check({tag, " ra"}, ra, era);
    check({tag, " link_we"}, 32'(link_we), 32'(el));
    check({tag, " ras_hit"}, 32'(ras_hit), 32'(eh));
    check({tag, " ras_empty"}, 32'(ras_empty), 32'(ee));
  endtask

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_stack[$];
  logic [31:0] m_t, m_ra, pc4, jt, topv;
  logic        m_red, m_lw, m_hit, m_emp;
  int          m_hits, m_miss;

  initial begin
    //          r  v  s  f  jal j jr ra pc            addr   rs           red tgt          ra           lw h  e
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h100,      26'd0, 32'h0,      0, 32'h0,       32'h0,       0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'd0, 32'h0,      0, 32'h0,       32'h0,       0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h00400000, 26'd10, 32'h0,     1, 32'h28,      32'h400004,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'd0, 32'h0,      0, 32'h28,      32'h400004,  0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h00400100, 26'd0, 32'h400004, 1, 32'h400004,  32'h400104,  0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h200,      26'd0, 32'h4,      1, 32'h4,       32'h204,     0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 32'h300,      26'd0, 32'h0,      0, 32'h4,       32'h204,     0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0,        26'd0, 32'h4,      1, 32'h4,       32'h4,       0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 32'h300,      26'd0, 32'h0,      0, 32'h4,       32'h4,       0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0,        26'd0, 32'h4,      1, 32'h4,       32'h4,       0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 32'h300,      26'd0, 32'h0,      0, 32'h4,       32'h4,       0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h100,      26'h40, 32'h0,     1, 32'h100,     32'h104,     1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h200,      26'h41, 32'h0,     1, 32'h104,     32'h204,     1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h300,      26'h42, 32'h0,     1, 32'h108,     32'h304,     1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h400,      26'h1, 32'h0,      0, 32'h0,       32'h0,       0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h400,      26'd0, 32'h304,    1, 32'h304,     32'h404,     0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h100,      26'd0, 32'h0,      1, 32'h0,       32'h104,     1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'h200,      26'd0, 32'h0,      1, 32'h0,       32'h204,     1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h500,      26'd0, 32'h999,    1, 32'h999,     32'h504,     0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 32'h0,        26'd0, 32'h1234,   1, 32'h1234,    32'h4,       0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 32'hF0000000, 26'd3, 32'h0,      1, 32'hF000000C, 32'hF0000004, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0,        26'd0, 32'h104,    1, 32'h104,     32'h4,       0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 1, 32'h600,      26'd1, 32'h0,      1, 32'h4,       32'h604,     1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 32'h0,        26'd2, 32'h0,      1, 32'h8,       32'h4,       0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0,        26'd0, 32'h604,    1, 32'h604,     32'h4,       0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFC, 26'd5, 32'h0,      1, 32'h14,      32'h0,       1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0,        26'd0, 32'h0,      1, 32'h0,       32'h4,       0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 32'h700,      26'd0, 32'h0,      0, 32'h0,       32'h4,       0, 0, 0));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'd0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'd0, 32'h0);
    check_out("reset", 0, 32'h0, 32'h0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].c,
            vecs[i].q, vecs[i].pc, vecs[i].ad, vecs[i].rs);
      check_out($sformatf("vec%0d", i), vecs[i].er, vecs[i].et, vecs[i].era, vecs[i].el,
                vecs[i].eh, vecs[i].ee);
    end

    // Overflow: nine pushes into an eight-deep stack, then LIFO pops.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'd0, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      drive(1, 1, 0, 0, 1, 0, 0, 0, 32'(k * 32'h100), 26'd0, 32'h0);
      check($sformatf("ovf push%0d ra", k), ra, 32'(k * 32'h100 + 4));
    end
    for (int k = 9; k >= 1; k--) begin
      drive(1, 1, 0, 0, 0, 0, 1, 1, 32'h0, 26'd0, 32'(k * 32'h100 + 4));
      check($sformatf("ovf pop%0d hit", k), 32'(ras_hit), (k >= 2) ? 32'd1 : 32'd0);
      check($sformatf("ovf pop%0d empty", k), 32'(ras_empty), (k == 1) ? 32'd1 : 32'd0);
    end

    // Mispredicted return after two pushes.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'd0, 32'h0);
    drive(1, 1, 0, 0, 1, 0, 0, 0, 32'h100, 26'd0, 32'h0);
    drive(1, 1, 0, 0, 1, 0, 0, 0, 32'h200, 26'd0, 32'h0);
    drive(1, 1, 0, 0, 0, 0, 1, 1, 32'h300, 26'd0, 32'h999);
    check_out("miss", 1, 32'h999, 32'h304, 0, 0, 0);
`ifdef JUMP_LINK_RAS_STATS_EN
    check("miss hit_cnt", 32'(hit_cnt), 32'd0);
    check("miss miss_cnt", 32'(miss_cnt), 32'd1);
`endif

    // Randomised run against a queue-based model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'd0, 32'h0);
    m_stack.delete();
    m_t = 0; m_ra = 0; m_hits = 0; m_miss = 0;
    for (int n = 0; n < 800; n++) begin
      logic        r, v, s, f, a, b, c, q;
      logic [31:0] p, rs;
      logic [25:0] ad;
      int          kind;
      r = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 7) == 0);
      kind = $urandom_range(0, 5);
      a = (kind == 1); b = (kind == 2); c = (kind == 3 || kind == 4);
      if (kind == 5) begin
        a = $urandom_range(0, 1) == 1; b = $urandom_range(0, 1) == 1; c = $urandom_range(0, 1) == 1;
      end
      q  = ($urandom_range(0, 3) != 0);
      p  = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000FFFC);
      ad = 26'($urandom());
      rs = (m_stack.size() > 0 && $urandom_range(0, 1) == 1) ? m_stack[$] : $urandom();

      m_red = 0; m_lw = 0; m_hit = 0; m_emp = 0;
      if (!r) begin
        m_stack.delete();
        m_t = 0; m_ra = 0; m_hits = 0; m_miss = 0;
      end else if (v && !s && !f && (a || b || c)) begin
        pc4   = p + 32'd4;
        jt    = {pc4[31:28], ad, 2'b00};
        m_red = 1;
        m_ra  = pc4;
        if (a) begin
          m_t  = jt;
          m_lw = 1;
          m_stack.push_back(pc4);
          if (m_stack.size() > 8) void'(m_stack.pop_front());
        end else if (b) begin
          m_t = jt;
        end else begin
          m_t = rs;
          if (q) begin
            if (m_stack.size() == 0) begin
              m_emp = 1;
              if (m_miss < 65535) m_miss++;
            end else begin
              topv  = m_stack.pop_back();
              m_hit = (topv == rs);
              if (m_hit && m_hits < 65535) m_hits++;
              if (!m_hit && m_miss < 65535) m_miss++;
            end
          end
        end
      end

      drive(r, v, s, f, a, b, c, q, p, ad, rs);
      check_out($sformatf("rnd%0d", n), m_red, m_t, m_ra, m_lw, m_hit, m_emp);
`ifdef JUMP_LINK_RAS_STATS_EN
      check($sformatf("rnd%0d hit_cnt", n), 32'(hit_cnt), 32'(m_hits));
      check($sformatf("rnd%0d miss_cnt", n), 32'(miss_cnt), 32'(m_miss));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
